dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 SHALL have parameter TIMEOUT_CYC, default 255: bus cycles to wait for bus_ack_i before aborting an access.
REQ-002 SHALL have the ports below; clk and rst_n come first. Clock is clk, single domain. Reset is rst_n, asynchronous and active-low.
- clk  in  1  core clock
- rst_n  in  1  async active-low reset
- mem_req_i  in  1  MEM stage has a load or store
- mem_we_i  in  1  1=store, 0=load
- mem_width_i  in  2  0=byte, 1=half, 2=word, 3=reserved
- mem_mtype_i  in  1  load extension: 0=sign, 1=zero
- mem_addr_i  in  32  byte address
- mem_wdata_i  in  32  store data, LSB-justified
- dmem_stall_flag_o  out  1  drives fc_Dcache_stall_flag_i
- dmem_rdata_o  out  32  aligned and extended load result
- dmem_rvalid_o  out  1  access complete this cycle
- dmem_err_o  out  1  misaligned access, reserved width or timeout; single-cycle pulse
- bus_req_o  out  1  bus request, held until acknowledged
- bus_we_o  out  1  bus write
- bus_addr_o  out  32  word address, bits [1:0] = 0
- bus_wdata_o  out  32  lane-replicated store data
- bus_wstrb_o  out  4  byte-lane strobes
- bus_ack_i  in  1  bus completion; bus_rdata_i valid with it
- bus_rdata_i  in  32  read word

Function
REQ-003 SHALL implement FSM states IDLE, BUS and DONE.
REQ-004 In IDLE with mem_req_i=1 and a legal access, SHALL latch we/width/mtype/addr/wdata, assert dmem_stall_flag_o combinationally in the same cycle, and go to BUS.
REQ-005 Legal access: width 0 at any address; width 1 with addr[0]=0; width 2 with addr[1:0]=0; width 3 is always illegal.
REQ-006 In IDLE with an illegal access, SHALL not stall, SHALL not touch the bus, SHALL pulse dmem_err_o and dmem_rvalid_o, SHALL drive dmem_rdata_o=0, and SHALL stay in IDLE.
REQ-007 In BUS, SHALL hold bus_req_o=1 and stall=1; all bus_* outputs SHALL come from latched values and SHALL be stable until ack.
REQ-008 In BUS on bus_ack_i=1, SHALL register the formatted load data (stores register 0), deassert bus_req_o next cycle, and go to DONE.
REQ-009 In DONE, SHALL drive stall=0 and dmem_rvalid_o=1, SHALL hold dmem_rdata_o, SHALL ignore mem_req_i (same instruction still present), and SHALL go to IDLE unconditionally.
REQ-010 Access latency SHALL be 1 cycle + bus latency: a request in cycle N with ack in cycle N+k gives rvalid in cycle N+k+1.
REQ-011 Timeout counter SHALL clear on entry to BUS and increment each BUS cycle without ack.
REQ-012 When the counter reaches TIMEOUT_CYC, SHALL abort to DONE with dmem_rdata_o=0 and a dmem_err_o pulse in DONE.
REQ-013 An ack arriving in the same cycle as the timeout SHALL win: normal completion, no error.
REQ-014 Load formatting, byte: lane = addr[1:0].
REQ-015 Load formatting, half: lane = addr[1].
REQ-016 Load formatting SHALL extend to 32 bits per mtype (0=sign, 1=zero); word loads pass through unchanged.
REQ-017 Store formatting, byte: wdata[7:0] replicated ×4, wstrb = 1<<addr[1:0].
REQ-018 Store formatting, half: wdata[15:0] replicated ×2, wstrb = 0011 or 1100 by addr[1].
REQ-019 Store formatting, word: wstrb = 1111.
REQ-020 For loads, bus_wstrb_o SHALL be 0000.
REQ-021 When bus_req_o=0, all other bus outputs SHALL be 0.
REQ-022 dmem_rdata_o SHALL hold its value until the next completion.

Reset
REQ-023 Asserting rst_n low SHALL immediately force IDLE and drive every output and register to 0, including mid-BUS.
REQ-024 A bus_ack_i arriving after reset aborts an access SHALL be ignored.

Structure
REQ-025 Package dmem_pkg SHALL hold the width encodings (BYTE/HALF/WORD), the mtype encoding and the FSM state encoding.
REQ-026 Sub-module dmem_align SHALL be combinational and SHALL contain legality check, load extract/extend, and store replicate/strobe; dmem_ctrl instantiates it once.

Verification
REQ-027 lw at 0x100, ack after 3 cycles with rdata 0xDEADBEEF -> stall high 4 cycles, then rvalid=1, rdata=0xDEADBEEF, err=0.
REQ-028 lb at 0x103, mtype=0, rdata 0x80123456 -> rdata=0xFFFFFF80; same with mtype=1 -> 0x00000080.
REQ-029 sh at 0x202, wdata 0x0000ABCD, immediate ack -> bus_addr=0x200, wdata=0xABCDABCD, wstrb=1100, rvalid 2 cycles after request.
REQ-030 lw at 0x101 -> no bus_req, stall=0, err=rvalid=1 same cycle, rdata=0.
REQ-031 TIMEOUT_CYC=4, no ack -> err=1 in DONE, rdata=0; repeat with ack on the 4th cycle -> no err.
REQ-032 rst_n low during BUS, then a stray ack -> all outputs 0, FSM in IDLE, no rvalid.

Source files
------------

// File: rtl/dmem_pkg.sv
// Shared encodings for the data-memory controller: access widths, load
// extension type and the controller FSM states.
package dmem_pkg;

    typedef enum logic [1:0] {
        WIDTH_BYTE = 2'd0,
        WIDTH_HALF = 2'd1,
        WIDTH_WORD = 2'd2,
        WIDTH_RSVD = 2'd3
    } width_e;

    typedef enum logic {
        MTYPE_SIGN = 1'b0,
        MTYPE_ZERO = 1'b1
    } mtype_e;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BUS  = 2'd1,
        ST_DONE = 2'd2
    } state_e;

endpackage

// File: rtl/dmem_align.sv
// Combinational alignment unit: access legality, load lane extract/extend
// and store lane replication/strobes.
module dmem_align
    import dmem_pkg::*;
(
    input  logic [1:0]  chk_width_i,
    input  logic [1:0]  chk_addr_lo_i,
    output logic        chk_legal_o,
    input  logic        fmt_we_i,
    input  logic [1:0]  fmt_width_i,
    input  logic        fmt_mtype_i,
    input  logic [1:0]  fmt_addr_lo_i,
    input  logic [31:0] fmt_wdata_i,
    input  logic [31:0] fmt_rdata_i,
    output logic [31:0] load_data_o,
    output logic [31:0] store_data_o,
    output logic [3:0]  store_strb_o
);

    logic [7:0]  byte_s;
    logic [15:0] half_s;
    logic        fill_b_s;
    logic        fill_h_s;

    // Legality of the incoming request (natural alignment, reserved width rejected)
    always_comb begin
        chk_legal_o = 1'b0;
        case (chk_width_i)
            WIDTH_BYTE: chk_legal_o = 1'b1;
            WIDTH_HALF: chk_legal_o = (chk_addr_lo_i[0] == 1'b0);
            WIDTH_WORD: chk_legal_o = (chk_addr_lo_i == 2'b00);
            default:    chk_legal_o = 1'b0;
        endcase
    end

    // Load lane selection and sign/zero extension
    always_comb begin
        byte_s      = 8'h00;
        half_s      = 16'h0000;
        load_data_o = 32'h0000_0000;
        case (fmt_addr_lo_i)
            2'b00:   byte_s = fmt_rdata_i[7:0];
            2'b01:   byte_s = fmt_rdata_i[15:8];
            2'b10:   byte_s = fmt_rdata_i[23:16];
            2'b11:   byte_s = fmt_rdata_i[31:24];
            default: byte_s = 8'h00;
        endcase
        if (fmt_addr_lo_i[1]) begin
            half_s = fmt_rdata_i[31:16];
        end else begin
            half_s = fmt_rdata_i[15:0];
        end
        fill_b_s = (fmt_mtype_i == MTYPE_SIGN) && byte_s[7];
        fill_h_s = (fmt_mtype_i == MTYPE_SIGN) && half_s[15];
        case (fmt_width_i)
            WIDTH_BYTE: load_data_o = {{24{fill_b_s}}, byte_s};
            WIDTH_HALF: load_data_o = {{16{fill_h_s}}, half_s};
            WIDTH_WORD: load_data_o = fmt_rdata_i;
            default:    load_data_o = 32'h0000_0000;
        endcase
    end

    // Store lane replication and byte strobes; loads never assert a strobe
    always_comb begin
        store_data_o = 32'h0000_0000;
        store_strb_o = 4'b0000;
        if (fmt_we_i) begin
            case (fmt_width_i)
                WIDTH_BYTE: begin
                    store_data_o = {4{fmt_wdata_i[7:0]}};
                    store_strb_o = 4'b0001 << fmt_addr_lo_i;
                end
                WIDTH_HALF: begin
                    store_data_o = {2{fmt_wdata_i[15:0]}};
                    store_strb_o = fmt_addr_lo_i[1] ? 4'b1100 : 4'b0011;
                end
                WIDTH_WORD: begin
                    store_data_o = fmt_wdata_i;
                    store_strb_o = 4'b1111;
                end
                default: begin
                    store_data_o = 32'h0000_0000;
                    store_strb_o = 4'b0000;
                end
            endcase
        end else begin
            store_data_o = 32'h0000_0000;
            store_strb_o = 4'b0000;
        end
    end

endmodule

// File: rtl/dmem_ctrl.sv
// Data-memory controller: turns MEM-stage loads/stores into single bus
// transactions, stalling the pipeline until the bus acknowledges or times out.
module dmem_ctrl
    import dmem_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = 255
)
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        mem_req_i,
    input  logic        mem_we_i,
    input  logic [1:0]  mem_width_i,
    input  logic        mem_mtype_i,
    input  logic [31:0] mem_addr_i,
    input  logic [31:0] mem_wdata_i,
    output logic        dmem_stall_flag_o,
    output logic [31:0] dmem_rdata_o,
    output logic        dmem_rvalid_o,
    output logic        dmem_err_o,
    output logic        bus_req_o,
    output logic        bus_we_o,
    output logic [31:0] bus_addr_o,
    output logic [31:0] bus_wdata_o,
    output logic [3:0]  bus_wstrb_o,
    input  logic        bus_ack_i,
    input  logic [31:0] bus_rdata_i
);

    localparam int unsigned CNT_W = (TIMEOUT_CYC < 2) ? 1 : $clog2(TIMEOUT_CYC);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_e          state_q, state_d;
    logic            we_q, we_d;
    logic [1:0]      width_q, width_d;
    logic            mtype_q, mtype_d;
    logic [31:0]     addr_q, addr_d;
    logic [31:0]     wdata_q, wdata_d;
    logic [31:0]     rdata_q, rdata_d;
    logic            err_q, err_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;

    logic            req_s;
    logic            legal_s;
    logic [31:0]     load_data_s;
    logic [31:0]     store_data_s;
    logic [3:0]      store_strb_s;

    // A request seen while reset is held must not leak onto the outputs
    assign req_s = mem_req_i & rst_n;

    dmem_align u_align (
        .chk_width_i   (mem_width_i),
        .chk_addr_lo_i (mem_addr_i[1:0]),
        .chk_legal_o   (legal_s),
        .fmt_we_i      (we_q),
        .fmt_width_i   (width_q),
        .fmt_mtype_i   (mtype_q),
        .fmt_addr_lo_i (addr_q[1:0]),
        .fmt_wdata_i   (wdata_q),
        .fmt_rdata_i   (bus_rdata_i),
        .load_data_o   (load_data_s),
        .store_data_o  (store_data_s),
        .store_strb_o  (store_strb_s)
    );

    // State and latched-access registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            we_q    <= 1'b0;
            width_q <= 2'b00;
            mtype_q <= 1'b0;
            addr_q  <= 32'h0000_0000;
            wdata_q <= 32'h0000_0000;
            rdata_q <= 32'h0000_0000;
            err_q   <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            we_q    <= we_d;
            width_q <= width_d;
            mtype_q <= mtype_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
            cnt_q   <= cnt_d;
        end
    end

    // Next-state and output decode
    always_comb begin
        state_d           = state_q;
        we_d              = we_q;
        width_d           = width_q;
        mtype_d           = mtype_q;
        addr_d            = addr_q;
        wdata_d           = wdata_q;
        rdata_d           = rdata_q;
        err_d             = err_q;
        cnt_d             = cnt_q;
        dmem_stall_flag_o = 1'b0;
        dmem_rvalid_o     = 1'b0;
        dmem_err_o        = 1'b0;
        dmem_rdata_o      = rdata_q;
        bus_req_o         = 1'b0;
        bus_we_o          = 1'b0;
        bus_addr_o        = 32'h0000_0000;
        bus_wdata_o       = 32'h0000_0000;
        bus_wstrb_o       = 4'b0000;
        case (state_q)
            ST_IDLE: begin
                if (req_s && legal_s) begin
                    we_d              = mem_we_i;
                    width_d           = mem_width_i;
                    mtype_d           = mem_mtype_i;
                    addr_d            = mem_addr_i;
                    wdata_d           = mem_wdata_i;
                    err_d             = 1'b0;
                    cnt_d             = '0;
                    dmem_stall_flag_o = 1'b1;
                    state_d           = ST_BUS;
                end else if (req_s) begin
                    // Illegal access completes at once with an error and no bus activity
                    dmem_err_o    = 1'b1;
                    dmem_rvalid_o = 1'b1;
                    dmem_rdata_o  = 32'h0000_0000;
                    rdata_d       = 32'h0000_0000;
                    state_d       = ST_IDLE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_BUS: begin
                dmem_stall_flag_o = 1'b1;
                bus_req_o         = 1'b1;
                bus_we_o          = we_q;
                bus_addr_o        = {addr_q[31:2], 2'b00};
                bus_wdata_o       = store_data_s;
                bus_wstrb_o       = store_strb_s;
                if (bus_ack_i) begin
                    rdata_d = we_q ? 32'h0000_0000 : load_data_s;
                    err_d   = 1'b0;
                    state_d = ST_DONE;
                end else if (cnt_q == CNT_LAST) begin
                    rdata_d = 32'h0000_0000;
                    err_d   = 1'b1;
                    state_d = ST_DONE;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_DONE: begin
                dmem_rvalid_o = 1'b1;
                dmem_err_o    = err_q;
                state_d       = ST_IDLE;
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dmem_ctrl.sv
// Randomized self-checking bench for dmem_ctrl against a transaction-level model.
module tb_dmem_ctrl;

    localparam int TMO = 4;

    logic        clk;
    logic        rst_n;
    logic        mem_req_i;
    logic        mem_we_i;
    logic [1:0]  mem_width_i;
    logic        mem_mtype_i;
    logic [31:0] mem_addr_i;
    logic [31:0] mem_wdata_i;
    logic        dmem_stall_flag_o;
    logic [31:0] dmem_rdata_o;
    logic        dmem_rvalid_o;
    logic        dmem_err_o;
    logic        bus_req_o;
    logic        bus_we_o;
    logic [31:0] bus_addr_o;
    logic [31:0] bus_wdata_o;
    logic [3:0]  bus_wstrb_o;
    logic        bus_ack_i;
    logic [31:0] bus_rdata_i;

    int          n_vec;
    int          n_err;
    logic [31:0] last_rdata;

    dmem_ctrl #(.TIMEOUT_CYC(TMO)) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .mem_req_i         (mem_req_i),
        .mem_we_i          (mem_we_i),
        .mem_width_i       (mem_width_i),
        .mem_mtype_i       (mem_mtype_i),
        .mem_addr_i        (mem_addr_i),
        .mem_wdata_i       (mem_wdata_i),
        .dmem_stall_flag_o (dmem_stall_flag_o),
        .dmem_rdata_o      (dmem_rdata_o),
        .dmem_rvalid_o     (dmem_rvalid_o),
        .dmem_err_o        (dmem_err_o),
        .bus_req_o         (bus_req_o),
        .bus_we_o          (bus_we_o),
        .bus_addr_o        (bus_addr_o),
        .bus_wdata_o       (bus_wdata_o),
        .bus_wstrb_o       (bus_wstrb_o),
        .bus_ack_i         (bus_ack_i),
        .bus_rdata_i       (bus_rdata_i)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic bit ref_legal(input logic [1:0] w, input logic [31:0] a);
        return (w == 2'd0) || (w == 2'd1 && a[0] == 1'b0) || (w == 2'd2 && a[1:0] == 2'd0);
    endfunction

    function automatic logic [31:0] ref_load(input logic [1:0] w, input logic mt,
                                             input logic [31:0] a, input logic [31:0] rd);
        logic [31:0] v;
        if (w == 2'd0) begin
            v = (rd >> (8 * a[1:0])) & 32'h0000_00FF;
            if (!mt && v[7]) v = v | 32'hFFFF_FF00;
        end else if (w == 2'd1) begin
            v = (rd >> (16 * a[1])) & 32'h0000_FFFF;
            if (!mt && v[15]) v = v | 32'hFFFF_0000;
        end else begin
            v = rd;
        end
        return v;
    endfunction

    function automatic logic [31:0] ref_sdata(input logic [1:0] w, input logic [31:0] wd);
        if (w == 2'd0) return (wd & 32'h0000_00FF) * 32'h0101_0101;
        if (w == 2'd1) return (wd & 32'h0000_FFFF) * 32'h0001_0001;
        return wd;
    endfunction

    function automatic logic [3:0] ref_strb(input logic we, input logic [1:0] w, input logic [31:0] a);
        if (!we) return 4'b0000;
        if (w == 2'd0) return 4'(1 << a[1:0]);
        if (w == 2'd1) return a[1] ? 4'b1100 : 4'b0011;
        return 4'b1111;
    endfunction

    task automatic chk_quiet(input string tag);
        chk({tag, "_stall"},  {31'd0, dmem_stall_flag_o}, 32'd0);
        chk({tag, "_rvalid"}, {31'd0, dmem_rvalid_o},     32'd0);
        chk({tag, "_err"},    {31'd0, dmem_err_o},        32'd0);
        chk({tag, "_busreq"}, {31'd0, bus_req_o},         32'd0);
        chk({tag, "_buswe"},  {31'd0, bus_we_o},          32'd0);
        chk({tag, "_busaddr"}, bus_addr_o,                32'd0);
        chk({tag, "_buswdata"}, bus_wdata_o,              32'd0);
        chk({tag, "_wstrb"},  {28'd0, bus_wstrb_o},       32'd0);
    endtask

    // One MEM-stage access; ack_at is the bus cycle (1 = first) carrying the ack,
    // any value beyond TMO means the bus never answers.
    task automatic access(input logic we, input logic [1:0] w, input logic mt,
                          input logic [31:0] a, input logic [31:0] wd,
                          input int ack_at, input logic [31:0] rd);
        bit          acked;
        logic [31:0] exp_rd;
        @(posedge clk); #1;
        mem_req_i   = 1'b1;
        mem_we_i    = we;
        mem_width_i = w;
        mem_mtype_i = mt;
        mem_addr_i  = a;
        mem_wdata_i = wd;
        bus_ack_i   = 1'b0;
        @(negedge clk);
        if (!ref_legal(w, a)) begin
            chk("ill_stall",  {31'd0, dmem_stall_flag_o}, 32'd0);
            chk("ill_err",    {31'd0, dmem_err_o},        32'd1);
            chk("ill_rvalid", {31'd0, dmem_rvalid_o},     32'd1);
            chk("ill_rdata",  dmem_rdata_o,               32'd0);
            chk("ill_busreq", {31'd0, bus_req_o},         32'd0);
            last_rdata = 32'd0;
        end else begin
            chk("req_stall",  {31'd0, dmem_stall_flag_o}, 32'd1);
            chk("req_rvalid", {31'd0, dmem_rvalid_o},     32'd0);
            chk("req_busreq", {31'd0, bus_req_o},         32'd0);
            acked = 1'b0;
            for (int c = 1; c <= TMO; c++) begin
                @(posedge clk); #1;
                bus_ack_i   = (c == ack_at);
                bus_rdata_i = (c == ack_at) ? rd : $urandom();
                mem_addr_i  = $urandom();
                mem_wdata_i = $urandom();
                @(negedge clk);
                chk("bus_req",    {31'd0, bus_req_o},         32'd1);
                chk("bus_stall",  {31'd0, dmem_stall_flag_o}, 32'd1);
                chk("bus_rvalid", {31'd0, dmem_rvalid_o},     32'd0);
                chk("bus_we",     {31'd0, bus_we_o},          {31'd0, we});
                chk("bus_addr",   bus_addr_o,                 {a[31:2], 2'b00});
                chk("bus_wstrb",  {28'd0, bus_wstrb_o},       {28'd0, ref_strb(we, w, a)});
                if (we) chk("bus_wdata", bus_wdata_o, ref_sdata(w, wd));
                if (c == ack_at) begin
                    acked = 1'b1;
                    break;
                end
            end
            @(posedge clk); #1;
            bus_ack_i   = 1'b0;
            bus_rdata_i = $urandom();
            @(negedge clk);
            exp_rd = (acked && !we) ? ref_load(w, mt, a, rd) : 32'd0;
            chk("done_rvalid", {31'd0, dmem_rvalid_o},     32'd1);
            chk("done_stall",  {31'd0, dmem_stall_flag_o}, 32'd0);
            chk("done_err",    {31'd0, dmem_err_o},        {31'd0, !acked});
            chk("done_rdata",  dmem_rdata_o,               exp_rd);
            chk("done_busreq", {31'd0, bus_req_o},         32'd0);
            chk("done_wstrb",  {28'd0, bus_wstrb_o},       32'd0);
            last_rdata = exp_rd;
        end
        @(posedge clk); #1;
        mem_req_i   = 1'b0;
        mem_addr_i  = $urandom();
        mem_width_i = 2'($urandom_range(0, 3));
        @(negedge clk);
        chk_quiet("idle");
        chk("idle_rdata", dmem_rdata_o, last_rdata);
    endtask

    initial begin
        n_vec       = 0;
        n_err       = 0;
        last_rdata  = 32'd0;
        rst_n       = 1'b0;
        mem_req_i   = 1'b0;
        mem_we_i    = 1'b0;
        mem_width_i = 2'd0;
        mem_mtype_i = 1'b0;
        mem_addr_i  = 32'd0;
        mem_wdata_i = 32'd0;
        bus_ack_i   = 1'b0;
        bus_rdata_i = 32'd0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_quiet("rst");
        chk("rst_rdata", dmem_rdata_o, 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        access(1'b0, 2'd2, 1'b0, 32'h0000_0100, 32'd0, 3, 32'hDEAD_BEEF);
        chk("lw_result", last_rdata, 32'hDEAD_BEEF);
        access(1'b0, 2'd0, 1'b0, 32'h0000_0103, 32'd0, 1, 32'h8012_3456);
        chk("lb_sign", last_rdata, 32'hFFFF_FF80);
        access(1'b0, 2'd0, 1'b1, 32'h0000_0103, 32'd0, 2, 32'h8012_3456);
        chk("lb_zero", last_rdata, 32'h0000_0080);
        access(1'b1, 2'd1, 1'b0, 32'h0000_0202, 32'h0000_ABCD, 1, 32'h1234_5678);
        access(1'b0, 2'd2, 1'b0, 32'h0000_0101, 32'd0, 1, 32'h1111_1111);
        access(1'b0, 2'd0, 1'b0, 32'h0000_0040, 32'd0, 1, 32'h0000_00AA);
        access(1'b0, 2'd3, 1'b0, 32'h0000_0000, 32'd0, 1, 32'h1111_1111);
        access(1'b0, 2'd1, 1'b0, 32'h0000_0003, 32'd0, 1, 32'h1111_1111);
        access(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'd0, TMO + 5, 32'h5555_5555);
        access(1'b0, 2'd2, 1'b0, 32'h0000_0300, 32'd0, TMO, 32'h5555_5555);
        access(1'b0, 2'd1, 1'b0, 32'h0000_0302, 32'd0, 1, 32'h8001_7FFF);

        // Reset in the middle of a bus access, then a stray ack
        @(posedge clk); #1;
        mem_req_i   = 1'b1;
        mem_we_i    = 1'b1;
        mem_width_i = 2'd2;
        mem_addr_i  = 32'h0000_0400;
        mem_wdata_i = 32'hCAFE_F00D;
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b0;
        #1;
        chk_quiet("midrst");
        chk("midrst_rdata", dmem_rdata_o, 32'd0);
        @(posedge clk); #1;
        rst_n       = 1'b1;
        mem_req_i   = 1'b0;
        bus_ack_i   = 1'b1;
        bus_rdata_i = 32'h9999_9999;
        @(negedge clk);
        chk_quiet("stray");
        chk("stray_rdata", dmem_rdata_o, 32'd0);
        @(posedge clk); #1;
        bus_ack_i = 1'b0;
        @(negedge clk);
        chk_quiet("post_stray");
        chk("post_stray_rdata", dmem_rdata_o, 32'd0);
        last_rdata = 32'd0;

        for (int i = 0; i < 300; i++) begin
            logic [31:0] a;
            a = $urandom();
            if ($urandom_range(0, 2) == 0) a[1:0] = 2'b00;
            access(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
                   a, $urandom(), int'($urandom_range(1, TMO + 2)), $urandom());
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
